// File: rtl/ysyx_22040125_mem_lsu.sv
// MEM-stage load/store unit: turns the EXE-register memory op into a multi-cycle
// data-bus transaction, formatting store data/strobes and extending load data.
module ysyx_22040125_mem_lsu #(
  parameter int TIMEOUT = 255,
  parameter int CNT_W   = 8
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req_valid,
  input  logic        req_wen,
  input  logic [63:0] req_addr,
  input  logic [63:0] req_wdata,
  input  logic [1:0]  req_size,
  input  logic        req_unsigned,
  input  logic [4:0]  req_rd,
  output logic        stall,
  output logic        resp_valid,
  output logic        resp_err,
  output logic [63:0] resp_rdata,
  output logic [4:0]  resp_rd,
  output logic        bus_valid,
  input  logic        bus_ready,
  output logic        bus_we,
  output logic [63:0] bus_addr,
  output logic [63:0] bus_wdata,
  output logic [7:0]  bus_wstrb,
  input  logic        bus_rvalid,
  input  logic [63:0] bus_rdata
);

  typedef enum logic [1:0] {IDLE, REQ, WAIT_R, DONE} state_t;

  state_t     state, state_nxt;
  logic [CNT_W-1:0] cnt;
  logic       wen_q, uns_q;
  logic [1:0] size_q;
  logic [2:0] off_q;
  logic [4:0] rd_q;

  logic        misalign, timeout_hit, err_nxt, load_ok;
  logic [63:0] sh, load_data;
  logic [7:0]  strb;

  assign stall       = req_valid & (state != DONE);
  assign timeout_hit = (cnt == CNT_W'(TIMEOUT - 1));
  assign load_ok     = (state == WAIT_R) & bus_rvalid;

  always_comb begin
    misalign = 1'b0;
    strb     = 8'hFF;
    case (req_size)
      2'b00: begin misalign = 1'b0;           strb = 8'h01 << req_addr[2:0]; end
      2'b01: begin misalign = req_addr[0];    strb = 8'h03 << req_addr[2:0]; end
      2'b10: begin misalign = |req_addr[1:0]; strb = 8'h0F << req_addr[2:0]; end
      default: begin misalign = |req_addr[2:0]; strb = 8'hFF; end
    endcase
  end

  assign sh = bus_rdata >> {off_q, 3'b000};

  always_comb begin
    load_data = sh;
    case (size_q)
      2'b00: load_data = {{56{~uns_q & sh[7]}},  sh[7:0]};
      2'b01: load_data = {{48{~uns_q & sh[15]}}, sh[15:0]};
      2'b10: load_data = {{32{~uns_q & sh[31]}}, sh[31:0]};
      default: load_data = sh;
    endcase
  end

  // A load's bus handshake is not completion, so it cannot rescue the last cycle.
  always_comb begin
    state_nxt = state;
    err_nxt   = 1'b0;
    case (state)
      IDLE:
        if (req_valid) begin
          state_nxt = misalign ? DONE : REQ;
          err_nxt   = misalign;
        end
      REQ:
        if (bus_ready && wen_q) state_nxt = DONE;
        else if (timeout_hit) begin
          state_nxt = DONE;
          err_nxt   = 1'b1;
        end else if (bus_ready) state_nxt = WAIT_R;
      WAIT_R:
        if (bus_rvalid) state_nxt = DONE;
        else if (timeout_hit) begin
          state_nxt = DONE;
          err_nxt   = 1'b1;
        end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state      <= IDLE;
      cnt        <= '0;
      wen_q      <= 1'b0;
      uns_q      <= 1'b0;
      size_q     <= 2'b00;
      off_q      <= 3'b000;
      rd_q       <= 5'd0;
      resp_valid <= 1'b0;
      resp_err   <= 1'b0;
      resp_rdata <= 64'd0;
      resp_rd    <= 5'd0;
      bus_valid  <= 1'b0;
      bus_we     <= 1'b0;
      bus_addr   <= 64'd0;
      bus_wdata  <= 64'd0;
      bus_wstrb  <= 8'd0;
    end else begin
      state      <= state_nxt;
      resp_valid <= (state != DONE) && (state_nxt == DONE);
      resp_err   <= err_nxt;
      resp_rdata <= load_ok ? load_data : 64'd0;
      resp_rd    <= load_ok ? rd_q : 5'd0;
      case (state)
        IDLE:
          if (req_valid) begin
            wen_q  <= req_wen;
            uns_q  <= req_unsigned;
            size_q <= req_size;
            off_q  <= req_addr[2:0];
            rd_q   <= req_rd;
            cnt    <= '0;
            if (!misalign) begin
              bus_valid <= 1'b1;
              bus_we    <= req_wen;
              bus_addr  <= {req_addr[63:3], 3'b000};
              bus_wdata <= req_wdata << {req_addr[2:0], 3'b000};
              bus_wstrb <= strb;
            end
          end
        REQ: begin
          cnt <= cnt + 1'b1;
          if (bus_ready || timeout_hit) bus_valid <= 1'b0;
        end
        WAIT_R: cnt <= cnt + 1'b1;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ysyx_22040125_mem_lsu.sv
// Randomized self-checking bench for the MEM-stage LSU against a transaction-level model.
module tb_ysyx_22040125_mem_lsu;

  localparam int T = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic        req_valid, req_wen, req_unsigned;
  logic [63:0] req_addr, req_wdata;
  logic [1:0]  req_size;
  logic [4:0]  req_rd;
  logic        stall, resp_valid, resp_err;
  logic [63:0] resp_rdata;
  logic [4:0]  resp_rd;
  logic        bus_valid, bus_ready, bus_we, bus_rvalid;
  logic [63:0] bus_addr, bus_wdata, bus_rdata;
  logic [7:0]  bus_wstrb;

  int n_chk = 0;
  int n_err = 0;

  ysyx_22040125_mem_lsu #(.TIMEOUT(T), .CNT_W(8)) dut (
    .clk(clk), .rst(rst),
    .req_valid(req_valid), .req_wen(req_wen), .req_addr(req_addr),
    .req_wdata(req_wdata), .req_size(req_size), .req_unsigned(req_unsigned),
    .req_rd(req_rd), .stall(stall), .resp_valid(resp_valid), .resp_err(resp_err),
    .resp_rdata(resp_rdata), .resp_rd(resp_rd), .bus_valid(bus_valid),
    .bus_ready(bus_ready), .bus_we(bus_we), .bus_addr(bus_addr),
    .bus_wdata(bus_wdata), .bus_wstrb(bus_wstrb), .bus_rvalid(bus_rvalid),
    .bus_rdata(bus_rdata)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  function automatic logic [63:0] m_load(logic [63:0] rdata, int off, int n, logic uns);
    logic [63:0] v = 64'd0;
    for (int i = 0; i < n; i++) v[8*i +: 8] = rdata[8*(off+i) +: 8];
    if (!uns && n < 8 && v[8*n-1])
      for (int j = n; j < 8; j++) v[8*j +: 8] = 8'hFF;
    return v;
  endfunction

  function automatic logic [63:0] m_wdata(logic [63:0] wdata, int off);
    logic [63:0] v = 64'd0;
    for (int i = 0; i + off < 8; i++) v[8*(i+off) +: 8] = wdata[8*i +: 8];
    return v;
  endfunction

  function automatic logic [7:0] m_strb(int off, int n);
    logic [7:0] s = 8'd0;
    for (int i = 0; i < n && off + i < 8; i++) s[off+i] = 1'b1;
    return s;
  endfunction

  // Entered and left at posedge+1 with the DUT idle. dr = REQ cycles before bus_ready,
  // drv = WAIT_R cycles before bus_rvalid.
  task automatic do_op(input logic wen, input logic [63:0] addr, input logic [63:0] wdata,
                       input logic [1:0] size, input logic uns, input logic [4:0] rd,
                       input int dr, input int drv, input logic [63:0] rdata);
    int n, off, ci, exp_stall, exp_reqc, stalls, reqc, waitc, cyc;
    bit mis, tout, hs, done;
    logic [63:0] e_rdata;
    logic [4:0]  e_rd;
    n    = 1 << size;
    off  = int'(addr[2:0]);
    mis  = (addr % n) != 0;
    ci   = wen ? dr : dr + 1 + drv;
    tout = !mis && ci > T - 1;
    exp_stall = mis ? 1 : (tout ? T + 1 : ci + 2);
    exp_reqc  = mis ? 0 : ((dr < T - 1 ? dr : T - 1) + 1);
    e_rdata = (!mis && !tout && !wen) ? m_load(rdata, off, n, uns) : 64'd0;
    e_rd    = (!mis && !tout && !wen) ? rd : 5'd0;

    chk("idle_resp_valid", resp_valid, 0);
    req_valid = 1'b1; req_wen = wen; req_addr = addr; req_wdata = wdata;
    req_size = size; req_unsigned = uns; req_rd = rd;
    stalls = 0; reqc = 0; waitc = 0; cyc = 0; hs = 0; done = 0;
    while (!done && cyc < 64) begin
      bus_ready  = 1'b0;
      bus_rvalid = 1'($urandom);
      bus_rdata  = {$urandom, $urandom};
      if (resp_valid) begin
        done = 1;
        chk("resp_err", resp_err, mis || tout);
        chk("resp_rdata", resp_rdata, e_rdata);
        chk("resp_rd", resp_rd, e_rd);
      end else if (hs) begin
        chk("bus_valid_wait", bus_valid, 0);
        bus_rvalid = (waitc == drv);
        if (waitc == drv) bus_rdata = rdata;
        waitc++;
      end else if (bus_valid) begin
        chk("bus_addr", bus_addr, {addr[63:3], 3'b000});
        chk("bus_we", bus_we, wen);
        chk("bus_wdata", bus_wdata, m_wdata(wdata, off));
        chk("bus_wstrb", bus_wstrb, m_strb(off, n));
        if (reqc == dr) begin
          bus_ready = 1'b1;
          if (!wen) hs = 1;
        end
        reqc++;
      end
      #1;
      if (stall) stalls++;
      @(posedge clk); #1;
      cyc++;
    end
    chk("resp_seen", done, 1);
    chk("stall_cycles", 64'(stalls), 64'(exp_stall));
    chk("bus_valid_cycles", 64'(reqc), 64'(exp_reqc));
    bus_ready = 1'b0; bus_rvalid = 1'b0;
  endtask

  task automatic idle(input int n);
    req_valid = 1'b0;
    for (int i = 0; i < n; i++) begin
      bus_ready  = 1'($urandom);
      bus_rvalid = 1'($urandom);
      bus_rdata  = {$urandom, $urandom};
      #1;
      chk("idle_stall", stall, 0);
      @(posedge clk); #1;
      chk("idle_no_resp", resp_valid, 0);
      chk("idle_no_bus", bus_valid, 0);
    end
    bus_ready = 1'b0; bus_rvalid = 1'b0;
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_bus_valid"}, bus_valid, 0);
    chk({tag, "_bus_we"}, bus_we, 0);
    chk({tag, "_bus_addr"}, bus_addr, 0);
    chk({tag, "_bus_wdata"}, bus_wdata, 0);
    chk({tag, "_bus_wstrb"}, bus_wstrb, 0);
    chk({tag, "_resp_valid"}, resp_valid, 0);
    chk({tag, "_resp_err"}, resp_err, 0);
    chk({tag, "_resp_rdata"}, resp_rdata, 0);
    chk({tag, "_resp_rd"}, resp_rd, 0);
  endtask

  initial begin
    logic [63:0] a;
    logic [1:0]  sz;
    rst = 1'b0; req_valid = 1'b0; req_wen = 1'b0; req_addr = '0; req_wdata = '0;
    req_size = '0; req_unsigned = 1'b0; req_rd = '0;
    bus_ready = 1'b0; bus_rvalid = 1'b0; bus_rdata = '0;
    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    chk("reset_stall", stall, 0);
    rst = 1'b1;
    @(posedge clk); #1;

    do_op(1'b1, 64'h8000_0005, 64'hAB, 2'b00, 1'b0, 5'd3, 1, 0, 64'd0);
    idle(1);
    do_op(1'b0, 64'h8000_0002, 64'd0, 2'b01, 1'b0, 5'd9, 0, 0, 64'h0000_0000_8001_0000);
    do_op(1'b0, 64'h8000_0002, 64'd0, 2'b01, 1'b1, 5'd9, 1, 1, 64'h0000_0000_8001_0000);
    do_op(1'b0, 64'h8000_0006, 64'd0, 2'b10, 1'b0, 5'd4, 0, 0, 64'hFFFF_FFFF_FFFF_FFFF);
    do_op(1'b1, 64'h8000_0010, 64'h1234, 2'b11, 1'b0, 5'd0, 20, 0, 64'd0);
    idle(3);
    do_op(1'b0, 64'h8000_0020, 64'd0, 2'b11, 1'b0, 5'd1, 1, 9, 64'h1122_3344_5566_7788);
    idle(2);
    do_op(1'b1, 64'h8000_0104, 64'hDEAD_BEEF, 2'b10, 1'b0, 5'd2, 0, 0, 64'd0);
    do_op(1'b0, 64'h8000_0108, 64'd0, 2'b11, 1'b0, 5'd31, 0, 0, 64'hCAFE_F00D_0BAD_BEEF);

    req_valid = 1'b1; req_wen = 1'b0; req_addr = 64'h100; req_size = 2'b11; req_rd = 5'd7;
    @(posedge clk); #1;
    chk("rst_mid_req", bus_valid, 1);
    bus_ready = 1'b1;
    @(posedge clk); #1;
    bus_ready = 1'b0; req_valid = 1'b0; rst = 1'b0;
    @(posedge clk); #1;
    chk_all_zero("rst_mid");
    rst = 1'b1;
    do_op(1'b0, 64'h200, 64'd0, 2'b10, 1'b0, 5'd7, 0, 1, 64'h8765_4321_0000_0000);

    for (int k = 0; k < 150; k++) begin
      sz = 2'($urandom);
      a  = {$urandom, $urandom};
      if ($urandom_range(0, 3) != 0) a = a & ~(64'(1 << sz) - 64'd1);
      do_op(1'($urandom), a, {$urandom, $urandom}, sz, 1'($urandom), 5'($urandom),
            $urandom_range(0, 4), $urandom_range(0, 3), {$urandom, $urandom});
      idle($urandom_range(0, 2));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_err);
    $finish;
  end

endmodule

// File: doc/ysyx_22040125_mem_lsu.md
Name:
ysyx_22040125_mem_lsu

Overview:
MEM-stage load/store unit. It takes the memory operation held in the EXE-stage pipeline register and runs it as a multi-cycle transaction on the data bus. Its responsibilities:
- align and byte-mask store data;
- extract, then sign- or zero-extend, load data;
- stall the pipeline until the transaction completes.

It sits between the EXE register outputs and the data-memory bus. It is the consumer of the EXE register's memory fields.

Parameters:
TIMEOUT, 255, number of cycles in REQ+WAIT_R after which the transaction is abandoned with an error.
CNT_W, 8, width of the timeout counter; must hold TIMEOUT.

Ports:
clk  in  1  system clock, all state updates on posedge
rst  in  1  synchronous active-low reset
req_valid  in  1  EXE register presents a memory op
req_wen  in  1  1=store, 0=load
req_addr  in  64  byte address
req_wdata  in  64  store data, LSB-aligned
req_size  in  2  00=byte, 01=half, 10=word, 11=double
req_unsigned  in  1  zero-extend load (ignored for size 11)
req_rd  in  5  load destination register
stall  out  1  combinational; hold upstream pipeline registers
resp_valid  out  1  one-cycle completion pulse
resp_err  out  1  valid with resp_valid; misaligned access or timeout
resp_rdata  out  64  extended load result; 0 for stores and errors
resp_rd  out  5  latched req_rd; 0 for stores
bus_valid  out  1  request valid
bus_ready  in  1  request accepted
bus_we  out  1  write enable
bus_addr  out  64  {req_addr[63:3],3'b000}
bus_wdata  out  64  req_wdata << (8*req_addr[2:0])
bus_wstrb  out  8  byte strobes
bus_rvalid  in  1  read data valid
bus_rdata  in  64  read data, 8-byte aligned

Behaviour:
- Reset:
  - Synchronous, active-low, applied at posedge clk when rst=0.
  - State returns to IDLE and the counter clears.
  - All registered outputs reset to 0: resp_*, bus_valid, bus_we, bus_addr, bus_wdata, bus_wstrb.
  - Reset mid-transaction abandons it; bus_valid is 0 in the cycle after reset is sampled.
- States: IDLE, REQ, WAIT_R, DONE.
- IDLE:
  - On req_valid, latch all req_* fields.
  - Misaligned request (low log2(bytes) address bits nonzero) -> DONE with err=1; no bus access.
  - Aligned request -> REQ with bus_valid=1 and bus fields formatted.
- REQ:
  - bus_valid=1; all bus fields are held stable until bus_ready.
  - On bus_ready, clear bus_valid; store -> DONE, load -> WAIT_R.
- WAIT_R:
  - bus_rvalid is sampled only in this state; it is earliest one cycle after the handshake.
  - On bus_rvalid, format the data -> DONE.
- DONE:
  - resp_valid=1 for exactly one cycle, stall=0, then IDLE.
  - req_valid seen during DONE is the old op and is not re-accepted.
- stall = req_valid & (state != DONE). Minimum latency:
  - misaligned op: 1 stall cycle;
  - store: 2 stall cycles;
  - load: 3 stall cycles.
- Timeout:
  - The counter clears on entry to REQ and increments each cycle in REQ or WAIT_R.
  - When the counter reaches TIMEOUT-1 without completion -> DONE, err=1, bus_valid dropped.
  - A late bus_rvalid arriving in IDLE or DONE is ignored.
- Write strobes, with off = addr[2:0]:
  - byte: 8'h01<<off
  - half: 8'h03<<off
  - word: 8'h0F<<off
  - double: 8'hFF
- Load data:
  - sh = bus_rdata >> (8*off).
  - byte, half and word take sh[7:0], sh[15:0] and sh[31:0], sign-extended, or zero-extended when req_unsigned=1.
  - double takes sh unchanged.
- On an error, resp_rdata=0 and resp_rd=0, so no register writeback occurs.

Test Plan:
- Byte store, addr=0x8000_0005, wdata=0xAB:
  - bus_addr=0x8000_0000, wstrb=8'h20, wdata=0x0000_AB00_0000_0000;
  - bus_ready on 2nd REQ cycle -> resp_valid, err=0; stall high for 3 cycles.
- Signed half load, addr=0x...2, bus_rdata=0x0000_0000_8001_0000 -> resp_rdata=0xFFFF_FFFF_FFFF_8001; with req_unsigned=1 -> 0x0000_0000_0000_8001; resp_rd=req_rd.
- Misaligned word load, addr=0x...6 -> no bus_valid; resp_valid+err next cycle; resp_rdata=0; stall high for 1 cycle.
- Timeout: TIMEOUT=4, bus_ready never asserted -> bus_valid for 4 cycles, then resp_valid with err=1; subsequent bus_rvalid ignored.
- Back-to-back ops, store then double load with no gap in req_valid:
  - exactly one resp_valid per op;
  - the second request is accepted only in the IDLE following DONE.
- Reset mid-transaction, rst=0 during WAIT_R -> next cycle state is IDLE, all outputs 0; a following load completes normally.
